// File: rtl/iter_alu.sv
// iter_alu: execution-side ALU driven by the 4-bit ALUSel code.
// Single-cycle arithmetic/logic ops; shifts iterate one bit per clock.
// Valid/ready handshakes on both the operand and result sides.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an operation, in_ready=1
// SHIFT  | iterative shift in progress, one bit per cycle
// DONE   | result and flags valid, held until out_ready
module iter_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            sign,
    output logic            carry,
    output logic            overflow,
    output logic            busy
);

    // ALUSel encodings ({funct7[5], funct3} style)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_sel;
    logic [XLEN-1:0] r_work;
    logic [SHW-1:0]  r_cnt;
    logic            r_msb;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_sign;
    logic            r_carry;
    logic            r_overflow;
    logic            r_out_valid;
    logic            r_in_ready;
    logic            r_busy;

    logic            w_accept;
    logic            w_is_shift;
    logic [SHW-1:0]  w_shamt;
    logic            w_is_sub;
    logic [XLEN-1:0] w_b_eff;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_res;
    logic            w_carry;
    logic            w_overflow;
    logic [XLEN-1:0] w_shift_next;

    assign w_accept = in_valid & r_in_ready;
    assign w_shamt  = op_b[SHW-1:0];
    assign w_is_sub = (alu_sel == ALU_SUB);
    assign w_b_eff  = w_is_sub ? ~op_b : op_b;
    assign w_sum    = {1'b0, op_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_is_sub};

    // Single-cycle datapath evaluated on the operands presented at accept
    always_comb begin
        w_res      = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_is_shift = 1'b0;
        case (alu_sel)
            ALU_ADD, ALU_SUB: begin
                w_res      = w_sum[XLEN-1:0];
                w_carry    = w_sum[XLEN];
                w_overflow = (op_a[XLEN-1] == w_b_eff[XLEN-1]) &&
                             (w_sum[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  w_res = op_a ^ op_b;
            ALU_OR:   w_res = op_a | op_b;
            ALU_AND:  w_res = op_a & op_b;
            // zero-amount shifts complete immediately with op_a unchanged
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                w_res      = op_a;
                w_is_shift = 1'b1;
            end
            default:  w_res = '0;
        endcase
    end

    // One-bit step of the working register for the latched shift type
    always_comb begin
        w_shift_next = r_work;
        case (r_sel)
            ALU_SLL: w_shift_next = {r_work[XLEN-2:0], 1'b0};
            ALU_SRL: w_shift_next = {1'b0, r_work[XLEN-1:1]};
            ALU_SRA: w_shift_next = {r_msb, r_work[XLEN-1:1]};
            default: w_shift_next = r_work;
        endcase
    end

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sel       <= ALU_ADD;
            r_work      <= '0;
            r_cnt       <= '0;
            r_msb       <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_sign      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel      <= alu_sel;
                        r_work     <= op_a;
                        r_cnt      <= w_shamt;
                        r_msb      <= op_a[XLEN-1];
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state     <= S_DONE;
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_sign      <= w_res[XLEN-1];
                            r_carry     <= w_carry;
                            r_overflow  <= w_overflow;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shift_next;
                    r_cnt  <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_state     <= S_DONE;
                        r_result    <= w_shift_next;
                        r_zero      <= (w_shift_next == '0);
                        r_sign      <= w_shift_next[XLEN-1];
                        r_carry     <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign zero      = r_zero;
    assign sign      = r_sign;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execution-side consumer of the 4-bit ALUSel code produced by the ALU control unit.
- Performs the selected operation on two XLEN-bit operands and returns the result plus condition flags for branch resolution.
- Shifts run iteratively, one bit per cycle; all other operations take a single cycle.
- Valid/ready handshakes on both the operand side and the result side so it can sit in a multi-cycle datapath.

Parameters:
- XLEN, 32, operand/result width.
- SHW, 5, shift-amount width (log2 XLEN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  unit can accept a new operation
- alu_sel  in  4  operation code, `ALU_* encodings from defines.v (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND)
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B; bits [SHW-1:0] are the shift amount for shifts
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- sign  out  1  result[XLEN-1]
- carry  out  1  carry-out of ADD; NOT borrow of SUB (1 when op_a >= op_b unsigned)
- overflow  out  1  signed overflow of ADD/SUB
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; result=0; zero=0; sign=0; carry=0; overflow=0; out_valid=0; busy=0; in_ready=1 after reset release.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). Accept occurs when in_valid & in_ready on a rising edge; alu_sel, op_a and op_b are latched internally on that edge.
- IDLE, accept of a non-shift op: compute, register result and flags, go to DONE. out_valid=1 on the next cycle (latency 1).
- IDLE, accept of SLL/SRL/SRA:
  - Load the working register with op_a and the counter with op_b[SHW-1:0].
  - Counter==0: go directly to DONE with result=op_a (latency 1).
  - Otherwise go to SHIFT.
- SHIFT: each cycle shift the working register by 1 and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the original bit XLEN-1.
  - When the counter reaches 1, the final shift is performed and the unit goes to DONE.
  - Total latency from accept to out_valid = shamt+1 cycles (shamt=31 gives 32 cycles).
- DONE: out_valid=1. result and flags are held stable until out_ready=1, then the unit goes to IDLE. A new op is never accepted in the same cycle as the result handoff.
- Arithmetic:
  - ADD/SUB use an XLEN+1-bit sum; SUB = op_a + ~op_b + 1.
  - overflow = (a[msb]==b'[msb]) & (sum[msb]!=a[msb]), where b' is op_b for ADD and ~op_b for SUB.
  - SLT: signed compare; SLTU: unsigned compare; result = {XLEN-1 zeros, lt}.
  - XOR/OR/AND are bitwise.
- Flags:
  - carry and overflow = 0 for every op other than ADD/SUB.
  - zero and sign are derived from the final result for all ops.
- Unlisted alu_sel code: result=0, zero=1, other flags 0, latency 1.
- Input changes while not in IDLE are ignored.
- Reset asserted mid-SHIFT or in DONE aborts the operation; the pending result is discarded and all outputs return to reset values.

Test Plan:
- ADD: op_a=0x7FFFFFFF, op_b=0x00000001, accept -> next cycle out_valid=1, result=0x80000000, overflow=1, carry=0, sign=1, zero=0.
- SUB: op_a=5, op_b=5 -> result=0, zero=1, carry=1, overflow=0. SUB op_a=0, op_b=1 -> result=0xFFFFFFFF, carry=0, sign=1.
- SRA: op_a=0x80000000, op_b=31 -> out_valid asserted exactly 32 cycles after accept, result=0xFFFFFFFF; in_ready=0 and busy=1 throughout. SRL with the same operands -> result=0x00000001.
- SLL shamt=0: op_a=0x1234, op_b=0x20 (low 5 bits = 0) -> latency 1, result=0x1234. SLT op_a=-1, op_b=1 -> 1; SLTU with the same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after an AND (0xF0F0 & 0x0FF0 = 0x00F0) -> result, flags and out_valid stay stable; in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-SLL (shamt=20, rst low at cycle 7) -> outputs immediately reset values, state IDLE. The first op after release (OR 0xA|0x5) -> result=0xF.
